// File: rtl/credit_tx.sv
// Credit-based transmitter feeding a CREDITS-deep downstream FIFO.
// It forwards a source word only while holding a credit, so the FIFO can never overrun.
module credit_tx #(
    parameter int WIDTH       = 8,
    parameter int CREDITS     = 4,
    parameter int WAIT_CYCLES = 2,
    parameter int CW          = $clog2(CREDITS + 1)
) (
    input  logic             clk,
    input  logic             reset_p,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_we,
    input  logic             credit_ret,
    output logic [CW-1:0]    credit_cnt,
    output logic             idle,
    output logic             err_ovf
);

    localparam int            HW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW:0]   CRED_MAX = (CW + 1)'(CREDITS);
    localparam logic [HW-1:0] HOLD_END = HW'(WAIT_CYCLES - 1);

    typedef enum logic {S_WAIT, S_RUN} state_t;

    state_t        state, state_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic          send;
    logic [CW:0]   cnt_sum;
    logic          cnt_ovf;

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state    <= S_WAIT;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // s_ready depends on registered state only, never on s_valid.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        s_ready   = 1'b0;
        case (state)
            S_WAIT: begin
                hold_nxt = hold_cnt + 1'b1;
                if (hold_cnt == HOLD_END)
                    state_nxt = S_RUN;
            end
            S_RUN: begin
                s_ready = (credit_cnt != '0);
            end
            default: state_nxt = S_WAIT;
        endcase
    end

    assign send    = s_valid & s_ready;
    assign cnt_sum = {1'b0, credit_cnt} - {{CW{1'b0}}, send} + {{CW{1'b0}}, credit_ret};
    assign cnt_ovf = (cnt_sum > CRED_MAX);

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            credit_cnt <= CRED_MAX[CW-1:0];
            tx_we      <= 1'b0;
            tx_data    <= '0;
            err_ovf    <= 1'b0;
        end else begin
            tx_we <= send;
            if (send)
                tx_data <= s_data;
            if (state == S_WAIT) begin
                // Downstream is still in reset, so any return here is bogus.
                if (credit_ret)
                    err_ovf <= 1'b1;
            end else if (cnt_ovf) begin
                credit_cnt <= CRED_MAX[CW-1:0];
                err_ovf    <= 1'b1;
            end else begin
                credit_cnt <= cnt_sum[CW-1:0];
            end
        end
    end

    assign idle = (state == S_RUN) && (credit_cnt == CRED_MAX[CW-1:0]) && !tx_we;

endmodule
